ingress_pkt_arbiter: RTL and testbench
======================================

Name: ingress_pkt_arbiter

Overview:
Shares the single packet receiver between NUM_SRC upstream packet sources. Grants are packet-atomic and round-robin.
- Muxes the granted source's valid/data/sop/eop onto the receiver input.
- Drives the receiver's ready_out backpressure from sink_ready.
- Flushes orphan words (words outside a packet).
- Enforces a maximum packet length and reports per-packet length and framing errors.

Parameters:
WORD_WIDTH, 32, data word width.
NUM_SRC, 4, number of upstream sources; legal range 2..8.
MAX_PKT_WORDS, 64, maximum words per packet; legal range 2..1023.

Ports:
clk  in  1  clock.
rst  in  1  reset: synchronous, active-high.
src_valid  in  NUM_SRC  per-source word valid.
src_data  in  NUM_SRC*WORD_WIDTH  per-source data; source i occupies bits [i*WORD_WIDTH +: WORD_WIDTH].
src_sop  in  NUM_SRC  per-source first-word flag.
src_eop  in  NUM_SRC  per-source last-word flag.
src_ready  out  NUM_SRC  per-source ready (combinational).
sink_ready  in  1  downstream can accept a word this cycle.
rx_valid  out  1  to receiver valid_in.
rx_data  out  WORD_WIDTH  to receiver data_in.
rx_sop  out  1  to receiver sop_in.
rx_eop  out  1  to receiver eop_in.
rx_ready  out  1  to receiver ready_out.
grant_id  out  $clog2(NUM_SRC)  currently granted source; valid only while pkt_active.
pkt_active  out  1  high in LOCK state.
pkt_done  out  1  one-cycle pulse, registered, the cycle after an eop transfer.
pkt_len  out  10  word count of the completed packet; valid with pkt_done, held until the next pkt_done.
err_orphan  out  NUM_SRC  registered pulse mask: orphan word(s) flushed, per source.
err_nested_sop  out  1  registered pulse: sop seen mid-packet.
err_overlength  out  1  registered pulse: packet truncated at MAX_PKT_WORDS.

Behaviour:
- Transfer on a port: valid && ready in the same cycle.
- Sources must hold data, sop and eop stable while valid is high and ready is low.
- Reset:
  - state=IDLE; last_grant=NUM_SRC-1, so source 0 has first priority.
  - word_cnt=0, pkt_len=0.
  - All registered outputs (pulses, pkt_len, grant_id, pkt_active) are 0.
  - Combinational outputs evaluate to 0 in IDLE with no orphans.
  - Reset mid-packet abandons the packet; no pkt_done and no error is reported.
- IDLE:
  - rx_valid=0, rx_ready=0.
  - Grant request: src_valid[i] && src_sop[i].
  - Winner: first requester searching from last_grant+1 with wrap (modulo NUM_SRC). Registered into grant_id; state goes to LOCK next cycle.
  - No word is transferred in the arbitration cycle. This gives a 1-cycle bubble between packets; first-word latency is 1 cycle from request.
  - Orphans: any source with src_valid && !src_sop gets src_ready=1. The word is discarded and err_orphan[i] pulses the next cycle. Several sources may be flushed in the same cycle.
  - Sop requests that lose arbitration see src_ready=0 and wait.
- LOCK (granted source g):
  - rx_valid=src_valid[g], rx_data=src_data[g].
  - rx_ready=sink_ready; src_ready[g]=sink_ready; all other src_ready=0.
  - rx_sop=src_sop[g] only on the first word (word_cnt==0); otherwise 0.
  - src_sop on a later word: the word is forwarded with sop stripped; err_nested_sop pulses.
  - Each transfer increments word_cnt.
  - Transfer with src_eop: pkt_len<=word_cnt+1, pkt_done pulses, last_grant<=g, word_cnt<=0, state goes to IDLE.
  - Transfer that is word number MAX_PKT_WORDS without eop: rx_eop is forced to 1 and the packet completes exactly as on eop (pkt_len=MAX_PKT_WORDS), plus err_overlength pulses. The source's remaining words become orphans.
  - Single-word packet (sop && eop): one LOCK cycle if sink_ready is high.
  - sink_ready low: stall, with no state or count change.
- Stateful registers: state, grant_id, last_grant, word_cnt, pkt_len, pulse flops. Everything else is combinational from these and the inputs.

Test Plan:
1. Reset, then source 1 sends a 3-word packet 0xA0..0xA2 with sink_ready=1 → grant_id=1 one cycle after request; rx words A0(sop), A1, A2(eop); pkt_done with pkt_len=3; src_ready[0,2,3]=0 throughout.
2. Sources 0 and 2 request simultaneously, with 2-word packets queued repeatedly → grant order 0,2,0,2; exactly 1 idle cycle between packets; no source starved.
3. Source 3 presents valid with sop=0 while IDLE → word flushed (src_ready[3]=1); err_orphan=4'b1000 next cycle; nothing appears on rx.
4. MAX_PKT_WORDS=4; source 0 sends 6 words with no eop → word 4 carries rx_eop=1; err_overlength pulses; pkt_len=4; words 5–6 flushed as orphans (err_orphan[0] pulses twice).
5. Mid-packet sop on word 2 of 3, with sink_ready toggled 1,0,0,1 → word 2 is forwarded with rx_sop=0; err_nested_sop pulses; stalled cycles hold rx_data stable with src_ready=0; pkt_len=3.
6. rst asserted during word 2 of 5 → next cycle: IDLE, pkt_active=0, no pkt_done; next arbitration favours source 0.

Source files
------------

// File: rtl/ingress_pkt_arbiter.sv
// Packet-atomic round-robin arbiter that shares one packet receiver between
// NUM_SRC upstream sources, flushing orphan words and capping packet length.
module ingress_pkt_arbiter #(
  parameter int WORD_WIDTH    = 32,
  parameter int NUM_SRC       = 4,
  parameter int MAX_PKT_WORDS = 64,
  localparam int SW           = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*WORD_WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]            src_sop,
  input  logic [NUM_SRC-1:0]            src_eop,
  output logic [NUM_SRC-1:0]            src_ready,
  input  logic                          sink_ready,
  output logic                          rx_valid,
  output logic [WORD_WIDTH-1:0]         rx_data,
  output logic                          rx_sop,
  output logic                          rx_eop,
  output logic                          rx_ready,
  output logic [SW-1:0]                 grant_id,
  output logic                          pkt_active,
  output logic                          pkt_done,
  output logic [9:0]                    pkt_len,
  output logic [NUM_SRC-1:0]            err_orphan,
  output logic                          err_nested_sop,
  output logic                          err_overlength
);

  // Handshake: a word moves on a port only in a cycle where valid && ready;
  // sources hold data/sop/eop stable while valid is high and ready is low.

  localparam logic [9:0] LAST_WORD = 10'(MAX_PKT_WORDS - 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t               state_q, state_d;
  logic [SW-1:0]        grant_q, grant_d;
  logic [SW-1:0]        last_q, last_d;
  logic [9:0]           cnt_q, cnt_d;
  logic [9:0]           len_q, len_d;
  logic                 done_q, done_d;
  logic [NUM_SRC-1:0]   orphan_q, orphan_d;
  logic                 nested_q, nested_d;
  logic                 over_q, over_d;

  logic [NUM_SRC-1:0]   req;
  logic [NUM_SRC-1:0]   orphans;
  logic                 found;
  logic [SW-1:0]        win;
  logic                 first_word;
  logic                 at_max;
  logic                 xfer;

  assign req     = src_valid & src_sop;
  assign orphans = src_valid & ~src_sop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= SW'(NUM_SRC - 1);
      cnt_q    <= '0;
      len_q    <= '0;
      done_q   <= 1'b0;
      orphan_q <= '0;
      nested_q <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      done_q   <= done_d;
      orphan_q <= orphan_d;
      nested_q <= nested_d;
      over_q   <= over_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    done_d     = 1'b0;
    orphan_d   = '0;
    nested_d   = 1'b0;
    over_d     = 1'b0;
    src_ready  = '0;
    rx_valid   = 1'b0;
    rx_data    = '0;
    rx_sop     = 1'b0;
    rx_eop     = 1'b0;
    rx_ready   = 1'b0;
    found      = 1'b0;
    win        = '0;
    first_word = 1'b0;
    at_max     = 1'b0;
    xfer       = 1'b0;

    case (state_q)
      IDLE: begin
        // Orphans are drained here so they never block a later sop behind them.
        src_ready = orphans;
        orphan_d  = orphans;
        for (int k = 1; k <= NUM_SRC; k++) begin
          if (!found && req[(int'(last_q) + k) % NUM_SRC]) begin
            found = 1'b1;
            win   = SW'((int'(last_q) + k) % NUM_SRC);
          end
        end
        if (found) begin
          grant_d = win;
          cnt_d   = '0;
          state_d = LOCK;
        end
      end

      LOCK: begin
        first_word         = (cnt_q == 10'd0);
        at_max             = (cnt_q == LAST_WORD);
        rx_valid           = src_valid[grant_q];
        rx_data            = src_data[grant_q*WORD_WIDTH +: WORD_WIDTH];
        rx_sop             = first_word & src_sop[grant_q];
        rx_eop             = src_eop[grant_q] | at_max;
        rx_ready           = sink_ready;
        src_ready[grant_q] = sink_ready;
        xfer               = src_valid[grant_q] & sink_ready;
        if (xfer) begin
          nested_d = !first_word && src_sop[grant_q];
          if (src_eop[grant_q] || at_max) begin
            len_d   = cnt_q + 10'd1;
            done_d  = 1'b1;
            over_d  = at_max && !src_eop[grant_q];
            last_d  = grant_q;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign grant_id       = grant_q;
  assign pkt_active     = (state_q == LOCK);
  assign pkt_done       = done_q;
  assign pkt_len        = len_q;
  assign err_orphan     = orphan_q;
  assign err_nested_sop = nested_q;
  assign err_overlength = over_q;

endmodule

// File: tb/tb_ingress_pkt_arbiter.sv
// Directed bench for ingress_pkt_arbiter with NUM_SRC=4 and MAX_PKT_WORDS=4.
module tb_ingress_pkt_arbiter;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   src_valid;
  logic [N*W-1:0] src_data;
  logic [N-1:0]   src_sop;
  logic [N-1:0]   src_eop;
  logic [N-1:0]   src_ready;
  logic           sink_ready;
  logic           rx_valid;
  logic [W-1:0]   rx_data;
  logic           rx_sop;
  logic           rx_eop;
  logic           rx_ready;
  logic [1:0]     grant_id;
  logic           pkt_active;
  logic           pkt_done;
  logic [9:0]     pkt_len;
  logic [N-1:0]   err_orphan;
  logic           err_nested_sop;
  logic           err_overlength;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  ingress_pkt_arbiter #(.WORD_WIDTH(W), .NUM_SRC(N), .MAX_PKT_WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_data(src_data), .src_sop(src_sop),
    .src_eop(src_eop), .src_ready(src_ready), .sink_ready(sink_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_sop(rx_sop), .rx_eop(rx_eop),
    .rx_ready(rx_ready), .grant_id(grant_id), .pkt_active(pkt_active),
    .pkt_done(pkt_done), .pkt_len(pkt_len), .err_orphan(err_orphan),
    .err_nested_sop(err_nested_sop), .err_overlength(err_overlength)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_src();
    src_valid = '0;
    src_data  = '0;
    src_sop   = '0;
    src_eop   = '0;
  endtask

  task automatic drive(input int i, input bit v, input logic [W-1:0] d, input bit s, input bit e);
    src_valid[i]       = v;
    src_data[i*W +: W] = d;
    src_sop[i]         = s;
    src_eop[i]         = e;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_src();
    step();
    step();
    rst = 1'b0;
  endtask

  logic [N-1:0] xfer;
  int widx[N];

  initial begin
    rst = 1'b1;
    sink_ready = 1'b1;
    clear_src();
    do_reset();

    // reset state
    #1;
    check("rst_active", pkt_active, 0);
    check("rst_grant", grant_id, 0);
    check("rst_len", pkt_len, 0);
    check("rst_done", pkt_done, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_src_ready", src_ready, 0);
    check("rst_errs", {err_orphan, err_nested_sop, err_overlength}, 0);

    // test 1: 3-word packet from source 1
    step();
    drive(1, 1, 32'hA0, 1, 0);
    #1;
    check("t1_arb_ready", src_ready, 4'b0000);
    check("t1_arb_rx_valid", rx_valid, 0);
    step();
    #1;
    check("t1_active", pkt_active, 1);
    check("t1_grant", grant_id, 1);
    check("t1_w0_data", rx_data, 32'hA0);
    check("t1_w0_sop", rx_sop, 1);
    check("t1_w0_eop", rx_eop, 0);
    check("t1_w0_ready", src_ready, 4'b0010);
    check("t1_rx_ready", rx_ready, 1);
    step();
    drive(1, 1, 32'hA1, 0, 0);
    #1;
    check("t1_w1_data", rx_data, 32'hA1);
    check("t1_w1_sop", rx_sop, 0);
    check("t1_w1_ready", src_ready, 4'b0010);
    step();
    drive(1, 1, 32'hA2, 0, 1);
    #1;
    check("t1_w2_data", rx_data, 32'hA2);
    check("t1_w2_eop", rx_eop, 1);
    check("t1_w2_ready", src_ready, 4'b0010);
    step();
    clear_src();
    #1;
    check("t1_done", pkt_done, 1);
    check("t1_len", pkt_len, 3);
    check("t1_idle", pkt_active, 0);
    step();
    #1;
    check("t1_done_pulse", pkt_done, 0);

    // test 2: sources 0 and 2 contend with back-to-back 2-word packets
    do_reset();
    exp_q.push_back(0);
    exp_q.push_back(2);
    exp_q.push_back(0);
    exp_q.push_back(2);
    widx[0] = 0;
    widx[2] = 0;
    drive(0, 1, 32'h00, 1, 0);
    drive(2, 1, 32'h20, 1, 0);
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      check($sformatf("t2_active_c%0d", cyc), pkt_active, (cyc % 3) != 0);
      if (rx_valid && rx_ready && rx_sop) begin
        if (exp_q.size() == 0) check("t2_extra_grant", grant_id, 32'hFFFF_FFFF);
        else check($sformatf("t2_grant_c%0d", cyc), grant_id, exp_q.pop_front());
      end
      xfer = src_valid & src_ready;
      step();
      for (int i = 0; i < N; i += 2) begin
        if (xfer[i]) begin
          widx[i] = 1 - widx[i];
          drive(i, 1, 32'(i * 16 + widx[i]), widx[i] == 0, widx[i] == 1);
        end
      end
    end
    check("t2_all_served", exp_q.size(), 0);
    clear_src();

    // test 3: orphan on source 3 while idle
    step();
    drive(3, 1, 32'h33, 0, 0);
    #1;
    check("t3_flush_ready", src_ready, 4'b1000);
    check("t3_rx_valid", rx_valid, 0);
    check("t3_rx_data", rx_data, 0);
    step();
    clear_src();
    #1;
    check("t3_err_orphan", err_orphan, 4'b1000);
    check("t3_active", pkt_active, 0);
    step();
    #1;
    check("t3_err_clear", err_orphan, 0);

    // test 4: 6 words without eop, truncated at 4
    drive(0, 1, 32'h41, 1, 0);
    #1;
    check("t4_arb_ready", src_ready, 0);
    step();
    for (int w = 1; w <= 4; w++) begin
      #1;
      check($sformatf("t4_w%0d_data", w), rx_data, 32'h40 + w);
      check($sformatf("t4_w%0d_eop", w), rx_eop, w == 4);
      step();
      if (w < 4) drive(0, 1, 32'(32'h41 + w), 0, 0);
    end
    drive(0, 1, 32'h45, 0, 0);
    #1;
    check("t4_done", pkt_done, 1);
    check("t4_len", pkt_len, 4);
    check("t4_overlength", err_overlength, 1);
    check("t4_w5_flush", src_ready, 4'b0001);
    check("t4_idle", pkt_active, 0);
    step();
    drive(0, 1, 32'h46, 0, 0);
    #1;
    check("t4_orphan1", err_orphan, 4'b0001);
    check("t4_over_pulse", err_overlength, 0);
    check("t4_w6_flush", src_ready, 4'b0001);
    step();
    clear_src();
    #1;
    check("t4_orphan2", err_orphan, 4'b0001);
    step();
    #1;
    check("t4_orphan_clear", err_orphan, 0);

    // test 5: nested sop on word 2, sink_ready 1,0,0,1
    drive(2, 1, 32'h51, 1, 0);
    sink_ready = 1'b1;
    #1;
    check("t5_arb_ready", src_ready, 0);
    step();
    #1;
    check("t5_grant", grant_id, 2);
    check("t5_w1_sop", rx_sop, 1);
    step();
    drive(2, 1, 32'h52, 1, 0);
    sink_ready = 1'b0;
    #1;
    check("t5_w2_sop", rx_sop, 0);
    check("t5_w2_data", rx_data, 32'h52);
    check("t5_stall_ready", src_ready, 0);
    check("t5_stall_rx_ready", rx_ready, 0);
    step();
    #1;
    check("t5_hold_data", rx_data, 32'h52);
    check("t5_hold_ready", src_ready, 0);
    check("t5_no_nested_yet", err_nested_sop, 0);
    step();
    sink_ready = 1'b1;
    #1;
    check("t5_resume_ready", src_ready, 4'b0100);
    step();
    drive(2, 1, 32'h53, 0, 1);
    #1;
    check("t5_nested", err_nested_sop, 1);
    check("t5_w3_data", rx_data, 32'h53);
    check("t5_w3_eop", rx_eop, 1);
    step();
    clear_src();
    #1;
    check("t5_done", pkt_done, 1);
    check("t5_len", pkt_len, 3);

    // test 6: reset during word 2 of a 5-word packet
    step();
    drive(1, 1, 32'h61, 1, 0);
    step();
    #1;
    check("t6_grant", grant_id, 1);
    step();
    drive(1, 1, 32'h62, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_src();
    drive(0, 1, 32'h70, 1, 0);
    drive(3, 1, 32'h73, 1, 0);
    #1;
    check("t6_active", pkt_active, 0);
    check("t6_no_done", pkt_done, 0);
    check("t6_no_err", {err_orphan, err_nested_sop, err_overlength}, 0);
    check("t6_len_cleared", pkt_len, 0);
    step();
    #1;
    check("t6_rearb_active", pkt_active, 1);
    check("t6_rearb_grant", grant_id, 0);
    check("t6_rearb_data", rx_data, 32'h70);
    clear_src();
    step();

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
